// File: rtl/johnson_seq_decoder_pkg.sv
// ---------------------------------------------------------------------------
// jsd_pkg
// Shared types and helpers for the Johnson sequence decoder.
//   jsd_state_t : checker FSM states (SEARCH, ACQ, LOCKED, ERROR)
//   jc_dec_t    : decode result {legal, idx}
//   jc_encode   : step index -> Johnson code for a given register width
//   jc_decode   : Johnson code -> {legal, idx} for a given register width
// The helpers work on a fixed maximum width (MAX_W) so one definition
// serves every WIDTH; callers zero-extend narrower codes.
// ---------------------------------------------------------------------------
package jsd_pkg;

  localparam int MAX_W     = 32;
  localparam int IDX_MAX_W = 6;

  typedef enum logic [1:0] {
    SEARCH,
    ACQ,
    LOCKED,
    ERROR
  } jsd_state_t;

  typedef struct packed {
    logic                 legal;
    logic [IDX_MAX_W-1:0] idx;
  } jc_dec_t;

  // Steps 0..width fill ones from the bottom; steps above width then
  // clear bits from the bottom while the upper bits stay set.
  function automatic logic [MAX_W-1:0] jc_encode(input int idx, input int width);
    logic [MAX_W-1:0] code;
    code = '0;
    for (int b = 0; b < MAX_W; b++) begin
      if (b < width) begin
        if (idx <= width) begin
          code[b] = (b < idx);
        end else begin
          code[b] = (b >= idx - width);
        end
      end
    end
    return code;
  endfunction

  // A code is legal only when it matches exactly one of the 2*width
  // sequence entries; the matching entry number is the step index.
  function automatic jc_dec_t jc_decode(input logic [MAX_W-1:0] code, input int width);
    jc_dec_t r;
    r = '0;
    for (int k = 0; k < 2 * MAX_W; k++) begin
      if ((k < 2 * width) && (code == jc_encode(k, width))) begin
        r.legal = 1'b1;
        r.idx   = IDX_MAX_W'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/johnson_seq_decoder_decode.sv
// ---------------------------------------------------------------------------
// jsd_decode
// Purely combinational legality check and step-index decode of one
// Johnson code sample.
// Ports:
//   code  in   WIDTH  Johnson code sample
//   legal out  1      code is one of the 2*WIDTH sequence entries
//   idx   out  IDXW   step index of the code (0 when illegal)
// ---------------------------------------------------------------------------
module jsd_decode
  import jsd_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [IDXW-1:0]  idx
);

  logic [MAX_W-1:0] code_ext;
  jc_dec_t          dec;
  logic             unused_idx_hi;

  // Widen the sample to the package width, decode it, and keep only the
  // index bits this WIDTH can actually produce.
  always_comb begin
    code_ext              = '0;
    code_ext[WIDTH-1:0]   = code;
    dec                   = jc_decode(code_ext, WIDTH);
    legal                 = dec.legal;
    idx                   = dec.idx[IDXW-1:0];
    unused_idx_hi         = ^(dec.idx >> IDXW);
  end

endmodule

// File: rtl/johnson_seq_decoder.sv
// ---------------------------------------------------------------------------
// johnson_seq_decoder
// Receive-side checker for a Johnson counter: decodes each valid sample to
// a step index, checks legality and step-to-step sequence, and reports
// lock, wrap and error status. All outputs are registered (1-cycle latency).
// Optional feature macro: JSD_BIDIR_EN (accept down-steps, adds port dir).
// Ports:
//   clk       in   1      rising-edge clock
//   clear     in   1      synchronous reset, active-high
//   jc_in     in   WIDTH  Johnson code sample
//   jc_valid  in   1      jc_in is sampled this cycle
//   idx_out   out  IDXW   step index of last legal valid sample
//   idx_valid out  1      pulse: idx_out/legal updated
//   legal     out  1      last valid sample was a legal code
//   locked    out  1      FSM is in LOCKED
//   seq_err   out  1      pulse: sequence/legality violation while LOCKED
//   wrap      out  1      pulse: LOCKED step N-1 -> 0 (or 0 -> N-1 down)
//   err_cnt   out  ERRW   saturating count of seq_err pulses
//   dir       out  1      (JSD_BIDIR_EN only) last accepted step was down
// ---------------------------------------------------------------------------
module johnson_seq_decoder
  import jsd_pkg::*;
#(
  parameter int  WIDTH    = 4,
  parameter int  LOCK_CNT = 3,
  parameter int  ERRW     = 8,
  localparam int N        = 2 * WIDTH,
  localparam int IDXW     = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] jc_in,
  input  logic             jc_valid,
  output logic [IDXW-1:0]  idx_out,
  output logic             idx_valid,
  output logic             legal,
  output logic             locked,
  output logic             seq_err,
  output logic             wrap,
  output logic [ERRW-1:0]  err_cnt
`ifdef JSD_BIDIR_EN
  ,
  output logic             dir
`endif
);

  localparam int RUNW = $clog2(LOCK_CNT + 1);

  jsd_state_t      state;
  logic [IDXW-1:0] exp_idx;
  logic [RUNW-1:0] run_cnt;

  logic            dec_legal;
  logic [IDXW-1:0] dec_idx;
  logic            step_fwd;
  logic            step_rev;
  logic            step_ok;
  logic            new_dir;
  logic [IDXW-1:0] next_exp;
  logic            step_wrap;

  // Index arithmetic compares against N-1 explicitly so that sequence
  // lengths that are not powers of two still wrap correctly.
  function automatic logic [IDXW-1:0] idx_inc(input logic [IDXW-1:0] x);
    return (x == IDXW'(N - 1)) ? '0 : x + IDXW'(1);
  endfunction

  function automatic logic [IDXW-1:0] idx_dec(input logic [IDXW-1:0] x);
    return (x == '0) ? IDXW'(N - 1) : x - IDXW'(1);
  endfunction

  jsd_decode #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_decode (
    .code  (jc_in),
    .legal (dec_legal),
    .idx   (dec_idx)
  );

  // Classify the current sample against the step history. idx_out holds
  // the previous accepted sample whenever the FSM is in ACQ or LOCKED, so
  // it serves as the "last index" for the reverse-step and wrap checks.
  // A reverse step is the neighbour on the far side of the last index
  // (exp-2 while counting up); accepting it flips the direction.
  always_comb begin
    step_fwd  = dec_legal && (dec_idx == exp_idx);
`ifdef JSD_BIDIR_EN
    step_rev  = dec_legal && !step_fwd &&
                (dec_idx == (dir ? idx_inc(idx_out) : idx_dec(idx_out)));
    new_dir   = dir ^ step_rev;
`else
    step_rev  = 1'b0;
    new_dir   = 1'b0;
`endif
    step_ok   = step_fwd || step_rev;
    next_exp  = new_dir ? idx_dec(dec_idx) : idx_inc(dec_idx);
    step_wrap = new_dir ? ((idx_out == '0) && (dec_idx == IDXW'(N - 1)))
                        : ((idx_out == IDXW'(N - 1)) && (dec_idx == '0));
  end

  // Checker FSM with registered outputs. Decode outputs follow every valid
  // sample (even in ERROR); the FSM only reacts to samples in SEARCH, ACQ
  // and LOCKED. ERROR always lasts one cycle. Starting an acquisition
  // resets the direction to up since no step has been accepted yet.
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= SEARCH;
      exp_idx   <= '0;
      run_cnt   <= '0;
      idx_out   <= '0;
      idx_valid <= 1'b0;
      legal     <= 1'b0;
      locked    <= 1'b0;
      seq_err   <= 1'b0;
      wrap      <= 1'b0;
      err_cnt   <= '0;
`ifdef JSD_BIDIR_EN
      dir       <= 1'b0;
`endif
    end else begin
      idx_valid <= jc_valid;
      seq_err   <= 1'b0;
      wrap      <= 1'b0;
      if (jc_valid) begin
        legal <= dec_legal;
        if (dec_legal) begin
          idx_out <= dec_idx;
        end
      end

      case (state)
        SEARCH: begin
          if (jc_valid && dec_legal) begin
            state   <= ACQ;
            exp_idx <= idx_inc(dec_idx);
            run_cnt <= '0;
`ifdef JSD_BIDIR_EN
            dir     <= 1'b0;
`endif
          end
        end

        ACQ: begin
          if (jc_valid) begin
            if (!dec_legal) begin
              state   <= SEARCH;
              run_cnt <= '0;
            end else if (step_ok) begin
              exp_idx <= next_exp;
              run_cnt <= run_cnt + RUNW'(1);
`ifdef JSD_BIDIR_EN
              dir     <= new_dir;
`endif
              if (run_cnt == RUNW'(LOCK_CNT - 1)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              exp_idx <= idx_inc(dec_idx);
              run_cnt <= '0;
`ifdef JSD_BIDIR_EN
              dir     <= 1'b0;
`endif
            end
          end
        end

        LOCKED: begin
          if (jc_valid) begin
            if (step_ok) begin
              exp_idx <= next_exp;
              wrap    <= step_wrap;
`ifdef JSD_BIDIR_EN
              dir     <= new_dir;
`endif
            end else begin
              seq_err <= 1'b1;
              state   <= ERROR;
              locked  <= 1'b0;
              if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERRW'(1);
              end
            end
          end
        end

        ERROR: begin
          state   <= SEARCH;
          run_cnt <= '0;
        end

        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_seq_decoder.sv
// ---------------------------------------------------------------------------
// tb_johnson_seq_decoder
// Directed bench for johnson_seq_decoder at WIDTH=4, LOCK_CNT=3, ERRW=8.
// Expected values are hand-computed from the Johnson sequence
// 0000,0001,0011,0111,1111,1110,1100,1000 = idx 0..7.
// Honours JSD_BIDIR_EN for the down-step scenario.
// ---------------------------------------------------------------------------
module tb_johnson_seq_decoder;

  logic       clk;
  logic       clear;
  logic [3:0] jc_in;
  logic       jc_valid;
  logic [2:0] idx_out;
  logic       idx_valid;
  logic       legal;
  logic       locked;
  logic       seq_err;
  logic       wrap;
  logic [7:0] err_cnt;
`ifdef JSD_BIDIR_EN
  logic       dir;
`endif

  int tests;
  int failures;

  johnson_seq_decoder #(
    .WIDTH    (4),
    .LOCK_CNT (3),
    .ERRW     (8)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .jc_in     (jc_in),
    .jc_valid  (jc_valid),
    .idx_out   (idx_out),
    .idx_valid (idx_valid),
    .legal     (legal),
    .locked    (locked),
    .seq_err   (seq_err),
    .wrap      (wrap),
    .err_cnt   (err_cnt)
`ifdef JSD_BIDIR_EN
    ,
    .dir       (dir)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one sample on the falling edge, then let the rising edge
  // register it and settle 1 ns before the caller inspects outputs.
  task automatic applyStimulus(input logic [3:0] code, input logic valid);
    @(negedge clk);
    jc_in    = code;
    jc_valid = valid;
    @(posedge clk);
    #1;
  endtask

  // One counted comparison.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Walk SEARCH -> ACQ -> LOCKED on 0000..0111 without checks.
  task automatic relock();
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0011, 1'b1);
    applyStimulus(4'b0111, 1'b1);
  endtask

  // Directed scenario sequence.
  initial begin
    tests    = 0;
    failures = 0;
    clear    = 1'b1;
    jc_valid = 1'b1;
    jc_in    = 4'b0001;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_idx_valid", idx_valid, 0);
    checkOutput("rst_idx_out",   idx_out,   0);
    checkOutput("rst_legal",     legal,     0);
    checkOutput("rst_locked",    locked,    0);
    checkOutput("rst_seq_err",   seq_err,   0);
    checkOutput("rst_wrap",      wrap,      0);
    checkOutput("rst_err_cnt",   err_cnt,   0);
    clear = 1'b0;

    applyStimulus(4'b0000, 1'b1);
    checkOutput("acq0_idx_valid", idx_valid, 1);
    checkOutput("acq0_legal",     legal,     1);
    checkOutput("acq0_idx",       idx_out,   0);
    checkOutput("acq0_locked",    locked,    0);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("acq1_locked", locked, 0);
    applyStimulus(4'b0011, 1'b1);
    checkOutput("acq2_locked", locked, 0);
    applyStimulus(4'b0111, 1'b1);
    checkOutput("lock_locked", locked, 1);
    checkOutput("lock_idx",    idx_out, 3);

    applyStimulus(4'b1111, 1'b1);
    checkOutput("s4_idx", idx_out, 4);
    applyStimulus(4'b1110, 1'b1);
    applyStimulus(4'b1100, 1'b1);
    applyStimulus(4'b1000, 1'b1);
    checkOutput("s7_idx",  idx_out, 7);
    checkOutput("s7_wrap", wrap,    0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("wrap_pulse",  wrap,    1);
    checkOutput("wrap_idx",    idx_out, 0);
    checkOutput("wrap_locked", locked,  1);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("wrap_end", wrap, 0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("idle_idx_valid", idx_valid, 0);
    checkOutput("idle_idx_hold",  idx_out,   1);
    checkOutput("idle_locked",    locked,    1);

    applyStimulus(4'b0101, 1'b1);
    checkOutput("ill_legal",   legal,   0);
    checkOutput("ill_seq_err", seq_err, 1);
    checkOutput("ill_err_cnt", err_cnt, 1);
    checkOutput("ill_locked",  locked,  0);
    checkOutput("ill_idx",     idx_out, 1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("errst_idx_valid", idx_valid, 1);
    checkOutput("errst_idx",       idx_out,   0);
    checkOutput("errst_seq_err",   seq_err,   0);
    checkOutput("errst_locked",    locked,    0);
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0011, 1'b1);
    applyStimulus(4'b0111, 1'b1);
    checkOutput("relock3_locked", locked, 0);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("relock4_locked", locked, 1);

    applyStimulus(4'b1100, 1'b1);
    checkOutput("skip_seq_err", seq_err, 1);
    checkOutput("skip_err_cnt", err_cnt, 2);
    checkOutput("skip_legal",   legal,   1);
    checkOutput("skip_locked",  locked,  0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("skip_pulse_end", seq_err, 0);

    for (int i = 0; i < 253; i++) begin
      relock();
      applyStimulus(4'b0101, 1'b1);
      applyStimulus(4'b0000, 1'b0);
    end
    checkOutput("sat_err_cnt_255", err_cnt, 255);
    relock();
    checkOutput("sat_relocked", locked, 1);
    applyStimulus(4'b0101, 1'b1);
    checkOutput("sat_seq_err", seq_err, 1);
    checkOutput("sat_err_cnt", err_cnt, 255);
    applyStimulus(4'b0000, 1'b0);

    relock();
    checkOutput("bidir_pre_locked", locked, 1);
    applyStimulus(4'b0011, 1'b1);
`ifdef JSD_BIDIR_EN
    checkOutput("down1_seq_err", seq_err, 0);
    checkOutput("down1_dir",     dir,     1);
    checkOutput("down1_locked",  locked,  1);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("down2_seq_err", seq_err, 0);
    checkOutput("down2_dir",     dir,     1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("down3_wrap", wrap, 0);
    applyStimulus(4'b1000, 1'b1);
    checkOutput("down_wrap",     wrap,    1);
    checkOutput("down_wrap_idx", idx_out, 7);
`else
    checkOutput("down_seq_err", seq_err, 1);
    checkOutput("down_locked",  locked,  0);
    checkOutput("down_err_cnt", err_cnt, 255);
    applyStimulus(4'b0000, 1'b0);
`endif

    relock();
    @(negedge clk);
    clear    = 1'b1;
    jc_in    = 4'b1111;
    jc_valid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_locked",    locked,    0);
    checkOutput("midrst_idx_valid", idx_valid, 0);
    checkOutput("midrst_idx",       idx_out,   0);
    checkOutput("midrst_legal",     legal,     0);
    checkOutput("midrst_err_cnt",   err_cnt,   0);
    clear    = 1'b0;
    jc_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
